cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among N_REQ functional-unit requesters, e.g. ALU, MUL/DIV, branch/jump and LSU.
- Each requester hands over a result (tag, ROB inst_id, wdata) through a valid/ready handshake into a one-entry holding buffer.
- A round-robin scheduler picks one buffered result per cycle and drives it onto the CDB, which feeds the ROB, reservation stations and rename forwarding.
- A pipeline flush empties all buffers.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TAG_W, 4, physical/rename tag width; tag value 0 means "no tag".
- ID_W, 4, ROB inst_id width; must equal the ROB pointer width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- flush  input  1  pipeline flush; same priority as rst for all internal state except rr_ptr.
- req_valid  input  N_REQ  per-requester result valid.
- req_ready  output  N_REQ  per-requester buffer can accept this cycle.
- req_tag  input  N_REQ*TAG_W  flattened tags; requester k uses bits [k*TAG_W +: TAG_W].
- req_inst_id  input  N_REQ*ID_W  flattened ROB ids.
- req_wdata  input  N_REQ*32  flattened result data.
- cdb_wr  output  1  CDB broadcast valid.
- cdb_tag  output  TAG_W  broadcast tag.
- cdb_inst_id  output  ID_W  broadcast ROB id.
- cdb_wdata  output  32  broadcast data.
- cdb_grant  output  N_REQ  one-hot source of the current broadcast, for debug and perf counters.

Behaviour:
- State:
  - per requester: buf_vld plus buffered tag, inst_id and wdata;
  - rr_ptr, $clog2(N_REQ) bits, marking the highest-priority requester.
- Reset (rst=1 at posedge): all buf_vld=0, rr_ptr=0.
  - While rst=1: req_ready=0, cdb_wr=0, cdb_grant=0; cdb_tag, cdb_inst_id and cdb_wdata are all 0.
- Grant (combinational from buffers):
  - Scan requesters starting at rr_ptr, wrapping modulo N_REQ.
  - The first k with buf_vld[k]=1 gets cdb_grant[k]=1, and cdb_* shows buffer k.
  - If no buffer is valid: cdb_wr=0, cdb_grant=0, data outputs 0.
- rr_ptr update: on a grant to k, rr_ptr <= (k+1) mod N_REQ; otherwise it holds.
- req_ready[k] = ~rst & ~flush & (~buf_vld[k] | cdb_grant[k]). A buffer that is draining this cycle accepts a new entry in the same cycle.
- Capture: when req_valid[k] & req_ready[k], the buffer loads the inputs and sets buf_vld=1 next cycle.
  - If granted with no new capture, buf_vld <= 0.
- Tag-0 filter: an accepted request with tag==0 is consumed (handshake completes) but buf_vld stays 0. It is never broadcast, because tag 0 would corrupt resolved operand fields downstream.
- Latency: accepted at edge t, broadcast no earlier than cycle t+1.
  - Worst-case wait is N_REQ-1 cycles after reaching the buffer.
  - Sustained throughput is 1 result per cycle total.
- Flush:
  - Next edge: all buf_vld <= 0; rr_ptr holds.
  - During the flush cycle, req_ready=0 and nothing is captured.
  - A combinational cdb_wr may still assert during the flush cycle; downstream consumers are also flushed that edge, so this is harmless.
- Simultaneous rst and flush: rst wins (rr_ptr also cleared).
- Requester holding req_valid while req_ready=0: its data must remain stable. The arbiter does not check this.

Optional Feature:
- Macro CDB_OUT_REG_EN.
- Defined: all cdb_* outputs come from a register stage loaded each cycle from the combinational grant result.
  - Latency becomes t+2.
  - The register clears to 0 on rst or flush, so no stale broadcast survives a flush.
  - Arbitration, rr_ptr and req_ready behaviour are unchanged.
- Undefined: cdb_* outputs are combinational from the buffers, as described in Behaviour.

Test Plan:
- Reset then idle: rst held 2 cycles, then released → req_ready=4'b1111, cdb_wr=0 every cycle, outputs all 0.
- Single request: req_valid=4'b0100, tag=3, inst_id=5, wdata=0xDEADBEEF at edge t → at t+1 cdb_wr=1, cdb_grant=4'b0100, tag 3, id 5, data 0xDEADBEEF; rr_ptr becomes 3.
- Fairness: all four valid every cycle with distinct tags 1..4 from rr_ptr=0 → grant order 0,1,2,3,0,1... with one cdb_wr per cycle, no gaps, req_ready stays 1 for each granted port.
- Tag-0 drop: req_valid[1]=1 with tag=0 → req_ready[1]=1 and the handshake completes; cdb_wr stays 0; buffer 1 remains empty.
- Flush mid-traffic: buffers 0 and 2 valid and flush=1 for one cycle → req_ready=0 that cycle; next cycle cdb_wr=0 and all buffers empty; new requests are accepted afterwards.
- CDB_OUT_REG_EN build: the single-request stimulus above → broadcast appears at t+2 with identical fields; flush asserted at t+1 → no broadcast at t+2.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Handshake and broadcast bundle between CDB requesters and the arbiter.
// Latency: none, wires only.
// Backpressure: req_ready per requester; the CDB itself is never stalled.
// Ports (slave = arbiter side):
//   req_valid/req_ready/req_tag/req_inst_id/req_wdata : per-requester result handshake (flattened lanes)
//   cdb_wr/cdb_tag/cdb_inst_id/cdb_wdata/cdb_grant   : broadcast bus and one-hot source
interface cdb_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int TAG_W = 4,
    parameter int ID_W  = 4
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*TAG_W-1:0] req_tag;
    logic [N_REQ*ID_W-1:0]  req_inst_id;
    logic [N_REQ*32-1:0]    req_wdata;
    logic                   cdb_wr;
    logic [TAG_W-1:0]       cdb_tag;
    logic [ID_W-1:0]        cdb_inst_id;
    logic [31:0]            cdb_wdata;
    logic [N_REQ-1:0]       cdb_grant;

    modport master (
        output req_valid, req_tag, req_inst_id, req_wdata,
        input  req_ready, cdb_wr, cdb_tag, cdb_inst_id, cdb_wdata, cdb_grant
    );

    modport slave (
        input  req_valid, req_tag, req_inst_id, req_wdata,
        output req_ready, cdb_wr, cdb_tag, cdb_inst_id, cdb_wdata, cdb_grant
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one common data bus among N_REQ one-entry result buffers.
// Latency: accept at edge t, broadcast from cycle t+1 (t+2 with CDB_OUT_REG_EN), worst wait N_REQ-1 cycles.
// Backpressure: req_ready[k] only while buffer k is empty or draining; deasserted during rst/flush.
// Ports: clk, rst (sync active-high), flush, bus (cdb_arbiter_if.slave).
// Optional macro CDB_OUT_REG_EN: registers all cdb_* outputs; register clears on rst or flush.
module cdb_arbiter #(
    parameter int N_REQ = 4,
    parameter int TAG_W = 4,
    parameter int ID_W  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] buf_vld;
    logic [TAG_W-1:0] buf_tag [N_REQ];
    logic [ID_W-1:0]  buf_id  [N_REQ];
    logic [31:0]      buf_dat [N_REQ];
    logic [PTR_W-1:0] rr_ptr;

    logic [N_REQ-1:0] grant;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_any;
    logic [N_REQ-1:0] ready;
    logic [N_REQ-1:0] capture;

    logic             cmb_wr;
    logic [TAG_W-1:0] cmb_tag;
    logic [ID_W-1:0]  cmb_id;
    logic [31:0]      cmb_dat;

    // Scan from rr_ptr with wrap; first valid buffer wins. Gated by rst so
    // nothing stale is shown while reset is held.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] idx_p;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        idx_p     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_p = idx[PTR_W-1:0];
            if (!grant_any && !rst && buf_vld[idx_p]) begin
                grant[idx_p] = 1'b1;
                grant_idx    = idx_p;
                grant_any    = 1'b1;
            end
        end
    end

    assign cmb_wr  = grant_any;
    assign cmb_tag = grant_any ? buf_tag[grant_idx] : '0;
    assign cmb_id  = grant_any ? buf_id[grant_idx]  : '0;
    assign cmb_dat = grant_any ? buf_dat[grant_idx] : '0;

    // A draining buffer can refill in the same cycle, giving 1 result/cycle.
    assign ready         = {N_REQ{~rst & ~flush}} & (~buf_vld | grant);
    assign capture       = bus.req_valid & ready;
    assign bus.req_ready = ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            buf_vld <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (capture[k]) begin
                    // Tag 0 completes the handshake but is never broadcast.
                    buf_vld[k] <= |bus.req_tag[k*TAG_W +: TAG_W];
                end else if (grant[k]) begin
                    buf_vld[k] <= 1'b0;
                end
            end
        end
    end

    // Payload needs no reset: it is qualified by buf_vld.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_REQ; k++) begin
            if (capture[k]) begin
                buf_tag[k] <= bus.req_tag[k*TAG_W +: TAG_W];
                buf_id[k]  <= bus.req_inst_id[k*ID_W +: ID_W];
                buf_dat[k] <= bus.req_wdata[k*32 +: 32];
            end
        end
    end

    // Pointer survives flush so fairness is not reset by mispredicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (!flush && grant_any) begin
            if (grant_idx == PTR_W'(N_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + 1'b1;
            end
        end
    end

`ifdef CDB_OUT_REG_EN
    logic             out_wr;
    logic [TAG_W-1:0] out_tag;
    logic [ID_W-1:0]  out_id;
    logic [31:0]      out_dat;
    logic [N_REQ-1:0] out_grant;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_wr    <= 1'b0;
            out_tag   <= '0;
            out_id    <= '0;
            out_dat   <= '0;
            out_grant <= '0;
        end else begin
            out_wr    <= cmb_wr;
            out_tag   <= cmb_tag;
            out_id    <= cmb_id;
            out_dat   <= cmb_dat;
            out_grant <= grant;
        end
    end

    assign bus.cdb_wr      = out_wr;
    assign bus.cdb_tag     = out_tag;
    assign bus.cdb_inst_id = out_id;
    assign bus.cdb_wdata   = out_dat;
    assign bus.cdb_grant   = out_grant;
`else
    assign bus.cdb_wr      = cmb_wr;
    assign bus.cdb_tag     = cmb_tag;
    assign bus.cdb_inst_id = cmb_id;
    assign bus.cdb_wdata   = cmb_dat;
    assign bus.cdb_grant   = grant;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (default build, combinational CDB outputs).
// Latency: broadcast checked one cycle after the accepting edge.
// Backpressure: req_ready checked against hand-derived buffer occupancy.
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int TW = 4;
    localparam int IW = 4;

    logic clk;
    logic rst;
    logic flush;

    int n_cmp;
    int n_err;

    cdb_arbiter_if #(.N_REQ(N), .TAG_W(TW), .ID_W(IW)) bus ();

    cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .ID_W(IW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next edge; inputs are driven here, outputs sampled after settle().
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_lane(input int k, input logic [TW-1:0] t, input logic [IW-1:0] id,
                            input logic [31:0] d);
        bus.req_tag[k*TW +: TW]     = t;
        bus.req_inst_id[k*IW +: IW] = id;
        bus.req_wdata[k*32 +: 32]   = d;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_wr"},    64'(bus.cdb_wr),    64'd0);
        chk({tag, "_grant"}, 64'(bus.cdb_grant), 64'd0);
        chk({tag, "_tag"},   64'(bus.cdb_tag),   64'd0);
        chk({tag, "_id"},    64'(bus.cdb_inst_id), 64'd0);
        chk({tag, "_data"},  64'(bus.cdb_wdata), 64'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        flush = 1'b0;
        bus.req_valid   = '0;
        bus.req_tag     = '0;
        bus.req_inst_id = '0;
        bus.req_wdata   = '0;

        // Reset held two cycles.
        for (int c = 0; c < 2; c++) begin
            tick();
            settle();
            chk("rst_ready", 64'(bus.req_ready), 64'h0);
            chk_idle("rst");
        end
        rst = 1'b0;
        settle();
        chk("idle_ready", 64'(bus.req_ready), 64'hF);
        chk_idle("idle0");
        tick();
        settle();
        chk_idle("idle1");

        // Single request on port 2.
        set_lane(2, 4'd3, 4'd5, 32'hDEADBEEF);
        bus.req_valid = 4'b0100;
        settle();
        chk("single_ready", 64'(bus.req_ready), 64'hF);
        tick();
        bus.req_valid = '0;
        settle();
        chk("single_wr",    64'(bus.cdb_wr),      64'd1);
        chk("single_grant", 64'(bus.cdb_grant),   64'b0100);
        chk("single_tag",   64'(bus.cdb_tag),     64'd3);
        chk("single_id",    64'(bus.cdb_inst_id), 64'd5);
        chk("single_data",  64'(bus.cdb_wdata),   64'hDEADBEEF);
        chk("single_ready2", 64'(bus.req_ready),  64'hF);
        tick();
        settle();
        chk_idle("single_done");

        // rr_ptr is now 3: with ports 0 and 3 pending, 3 wins first.
        set_lane(0, 4'd1, 4'd0, 32'h100);
        set_lane(3, 4'd4, 4'd3, 32'h103);
        bus.req_valid = 4'b1001;
        tick();
        bus.req_valid = '0;
        settle();
        chk("ptr3_grant", 64'(bus.cdb_grant), 64'b1000);
        chk("ptr3_tag",   64'(bus.cdb_tag),   64'd4);
        tick();
        settle();
        chk("ptr3_grant2", 64'(bus.cdb_grant), 64'b0001);
        // rr_ptr now 1; a lone grant to port 3 brings it back to 0.
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = '0;
        settle();
        chk("wrap_grant", 64'(bus.cdb_grant), 64'b1000);
        tick();
        settle();
        chk("wrap_idle", 64'(bus.cdb_wr), 64'd0);

        // Fairness: all four ports valid every cycle, rr_ptr starting at 0.
        for (int k = 0; k < N; k++) begin
            set_lane(k, TW'(k + 1), IW'(k + 8), 32'h200 + 32'(k));
        end
        bus.req_valid = 4'b1111;
        settle();
        chk("fair_ready0", 64'(bus.req_ready), 64'hF);
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 7) bus.req_valid = '0;
            settle();
            chk($sformatf("fair_wr%0d", c),    64'(bus.cdb_wr),      64'd1);
            chk($sformatf("fair_grant%0d", c), 64'(bus.cdb_grant),   64'(1 << (c % 4)));
            chk($sformatf("fair_tag%0d", c),   64'(bus.cdb_tag),     64'((c % 4) + 1));
            chk($sformatf("fair_data%0d", c),  64'(bus.cdb_wdata),   64'(32'h200 + (c % 4)));
            if (c != 7)
                chk($sformatf("fair_ready%0d", c), 64'(bus.req_ready), 64'(1 << (c % 4)));
        end
        // Port 3 drained without refill at that edge; 0,1,2 still hold entries.
        for (int d = 0; d < 3; d++) begin
            tick();
            settle();
            chk($sformatf("drain_grant%0d", d), 64'(bus.cdb_grant), 64'(1 << d));
        end
        tick();
        settle();
        chk_idle("drain_done");
        chk("drain_ready", 64'(bus.req_ready), 64'hF);

        // Tag-0 request: consumed, never broadcast. rr_ptr is 3 here.
        set_lane(1, 4'd0, 4'd7, 32'hCAFE0000);
        bus.req_valid = 4'b0010;
        settle();
        chk("tag0_ready", 64'(bus.req_ready[1]), 64'd1);
        tick();
        bus.req_valid = '0;
        settle();
        chk("tag0_wr",    64'(bus.cdb_wr),    64'd0);
        chk("tag0_ready2", 64'(bus.req_ready), 64'hF);
        tick();
        settle();
        chk("tag0_wr2",   64'(bus.cdb_wr),    64'd0);

        // Flush with buffers 0 and 2 full; requests offered during flush are refused.
        set_lane(0, 4'd5, 4'd1, 32'h300);
        set_lane(2, 4'd6, 4'd2, 32'h302);
        bus.req_valid = 4'b0101;
        tick();
        bus.req_valid = 4'b1111;
        flush = 1'b1;
        settle();
        chk("flush_ready", 64'(bus.req_ready), 64'h0);
        tick();
        flush = 1'b0;
        bus.req_valid = '0;
        settle();
        chk_idle("flush_after");
        chk("flush_ready2", 64'(bus.req_ready), 64'hF);
        // rr_ptr held at 3 through flush: port 3 beats port 0.
        set_lane(0, 4'd7, 4'd4, 32'h400);
        set_lane(3, 4'd8, 4'd5, 32'h403);
        bus.req_valid = 4'b1001;
        tick();
        bus.req_valid = '0;
        settle();
        chk("postflush_grant", 64'(bus.cdb_grant), 64'b1000);
        chk("postflush_tag",   64'(bus.cdb_tag),   64'd8);
        tick();
        settle();
        chk("postflush_grant2", 64'(bus.cdb_grant), 64'b0001);
        chk("postflush_data2",  64'(bus.cdb_wdata), 64'h400);
        tick();
        settle();
        chk("postflush_idle", 64'(bus.cdb_wr), 64'd0);

        // rst together with flush clears rr_ptr (currently 1) back to 0.
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        bus.req_valid = 4'b1001;
        tick();
        bus.req_valid = '0;
        settle();
        chk("rstflush_grant", 64'(bus.cdb_grant), 64'b0001);
        chk("rstflush_tag",   64'(bus.cdb_tag),   64'd7);
        tick();
        settle();
        chk("rstflush_grant2", 64'(bus.cdb_grant), 64'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
